// File: rtl/approx_product_accumulator.sv
// Frame accumulator for 8-bit approximate products: sums up to LEN beats per frame
// and hands out sum, count and overflow over a valid/ready port.
module approx_product_accumulator #(
  parameter int ACC_W    = 16,
  parameter int LEN      = 8,
  parameter bit SATURATE = 1'b1,
  localparam int CNT_W   = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               beat;
  logic               frame_close;
  logic [ACC_W:0]     nsum;
  logic [ACC_W-1:0]   acc_new;
  logic               ovf_new;

  assign beat        = in_valid & in_ready_q;
  assign frame_close = in_last | (cnt_q == CNT_W'(LEN - 1));

  // One extra bit catches the carry; a saturated acc re-overflows on every
  // non-zero add, so it stays pinned at all-ones for the rest of the frame.
  assign nsum    = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_product};
  assign acc_new = (nsum[ACC_W] && SATURATE) ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];
  assign ovf_new = ovf_q | nsum[ACC_W];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ST_ACCUM: begin
        if (beat) begin
          acc_d = acc_new;
          ovf_d = ovf_new;
          if (frame_close) begin
            out_sum_d   = acc_new;
            out_count_d = cnt_q + CNT_W'(1);
            out_ovf_d   = ovf_new;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: begin
        state_d     = ST_ACCUM;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule
